// File: rtl/web_trigger_sequencer.sv
// Button front-end for the web shooter: debounces fire/refill and emits mutually
// exclusive, fixed-width trigger/refill pulses, including RAPID-mode bursts.
`timescale 1ns/1ps
module web_trigger_sequencer #(
    parameter int DEBOUNCE    = 4,
    parameter int HOLD        = 6,
    parameter int GAP         = 6,
    parameter int REFILL_HOLD = 6,
    parameter int BURST_MAX   = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire_btn,
    input  logic             refill_btn,
    input  logic [2:0]       fire_mode,
    input  logic             not_enough,
    output logic             trigger,
    output logic             refill,
    output logic             burst_active,
    output logic [CNT_W-1:0] shots_fired
);

    localparam logic [2:0] MODE_RAPID = 3'b100;
    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int PH_MAX = (HOLD > GAP) ? ((HOLD > REFILL_HOLD) ? HOLD : REFILL_HOLD)
                                         : ((GAP > REFILL_HOLD) ? GAP : REFILL_HOLD);
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BC_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        FIRE_HIGH,
        FIRE_GAP,
        LOCKOUT,
        REFILL_HIGH
    } state_t;

    // Index 0 is the fire button, index 1 the refill button.
    logic [1:0]      raw;
    logic [1:0]      deb;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    assign raw = {refill_btn, fire_btn};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb   <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (raw[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                    deb[i]    <= raw[i];
                    press[i]  <= raw[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    state_t          state, state_n;
    logic [PH_W-1:0] phase, phase_n;
    logic [BC_W-1:0] burst_cnt, burst_n;
    logic [2:0]      mode_q, mode_n;
    logic            abort_q, abort_n;
    logic            shot;

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_n = state;
        phase_n = phase + 1'b1;
        mode_n  = mode_q;
        burst_n = burst_cnt;
        abort_n = abort_q;
        shot    = 1'b0;
        case (state)
            IDLE: begin
                phase_n = '0;
                if (press[0]) begin
                    state_n = FIRE_HIGH;
                    mode_n  = fire_mode;
                    burst_n = BC_W'(1);
                    abort_n = 1'b0;
                    shot    = 1'b1;
                end else if (press[1]) begin
                    state_n = REFILL_HIGH;
                end
            end
            FIRE_HIGH: begin
                if (not_enough) abort_n = 1'b1;
                if (phase == PH_W'(HOLD - 1)) begin
                    state_n = FIRE_GAP;
                    phase_n = '0;
                end
            end
            FIRE_GAP: begin
                if (not_enough) abort_n = 1'b1;
                if (phase == PH_W'(GAP - 1)) begin
                    phase_n = '0;
                    // The stored abort decides; a not_enough on this very edge only
                    // affects bursts it can no longer extend.
                    if (mode_q == MODE_RAPID && deb[0] && burst_cnt < BC_W'(BURST_MAX) && !abort_q) begin
                        state_n = FIRE_HIGH;
                        burst_n = burst_cnt + 1'b1;
                        shot    = 1'b1;
                    end else if (deb[0]) begin
                        state_n = LOCKOUT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                phase_n = '0;
                if (!deb[0]) state_n = IDLE;
            end
            REFILL_HIGH: begin
                if (phase == PH_W'(REFILL_HOLD - 1)) begin
                    state_n = IDLE;
                    phase_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase
    end

    // NOTE: outputs are decoded from the next state so they are registered yet
    // line up with the state they describe, and reset clears them on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            burst_cnt    <= '0;
            mode_q       <= '0;
            abort_q      <= 1'b0;
            trigger      <= 1'b0;
            refill       <= 1'b0;
            burst_active <= 1'b0;
            shots_fired  <= '0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            burst_cnt    <= burst_n;
            mode_q       <= mode_n;
            abort_q      <= abort_n;
            trigger      <= (state_n == FIRE_HIGH);
            refill       <= (state_n == REFILL_HIGH);
            burst_active <= (state_n == FIRE_HIGH || state_n == FIRE_GAP) && (mode_n == MODE_RAPID);
            if (shot && shots_fired != '1) shots_fired <= shots_fired + 1'b1;
        end
    end

endmodule

// File: tb/tb_web_trigger_sequencer.sv
// Bench for web_trigger_sequencer: directed table, hand-written corner sequences,
// and random stimulus against a cycle-level behavioural model with pulse monitors.
`timescale 1ns/1ps
module tb_web_trigger_sequencer;

    localparam int DEBOUNCE    = 4;
    localparam int HOLD        = 6;
    localparam int GAP         = 6;
    localparam int REFILL_HOLD = 6;
    localparam int BURST_MAX   = 8;
    localparam int CNT_W       = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             fire_btn;
    logic             refill_btn;
    logic [2:0]       fire_mode;
    logic             not_enough;
    logic             trigger;
    logic             refill;
    logic             burst_active;
    logic [CNT_W-1:0] shots_fired;

    web_trigger_sequencer #(
        .DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .GAP(GAP), .REFILL_HOLD(REFILL_HOLD),
        .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .fire_btn(fire_btn), .refill_btn(refill_btn),
        .fire_mode(fire_mode), .not_enough(not_enough), .trigger(trigger),
        .refill(refill), .burst_active(burst_active), .shots_fired(shots_fired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: activity codes plus "cycles remaining" countdowns.
    localparam int M_IDLE = 0, M_HIGH = 1, M_GAP = 2, M_LOCK = 3, M_REF = 4;
    int       m_act = M_IDLE;
    int       m_rem = 0;
    int       m_burst = 0;
    int       m_shots = 0;
    bit       m_abort = 0;
    bit [2:0] m_mode = 0;
    bit       m_deb [2] = '{0, 0};
    int       m_run [2] = '{0, 0};
    bit       m_press [2] = '{0, 0};

    function automatic void model_step();
        bit raw [2];
        raw[0] = fire_btn;
        raw[1] = refill_btn;
        if (rst) begin
            m_act = M_IDLE; m_rem = 0; m_burst = 0; m_shots = 0; m_abort = 0; m_mode = 0;
            for (int i = 0; i < 2; i++) begin m_deb[i] = 0; m_run[i] = 0; m_press[i] = 0; end
            return;
        end
        case (m_act)
            M_IDLE: begin
                if (m_press[0]) begin
                    m_act = M_HIGH; m_rem = HOLD; m_mode = fire_mode; m_burst = 1; m_abort = 0;
                    m_shots = (m_shots < 255) ? m_shots + 1 : 255;
                end else if (m_press[1]) begin
                    m_act = M_REF; m_rem = REFILL_HOLD;
                end
            end
            M_HIGH: begin
                if (not_enough) m_abort = 1;
                m_rem--;
                if (m_rem == 0) begin m_act = M_GAP; m_rem = GAP; end
            end
            M_GAP: begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_mode == 3'b100 && m_deb[0] && m_burst < BURST_MAX && !m_abort) begin
                        m_act = M_HIGH; m_rem = HOLD; m_burst++;
                        m_shots = (m_shots < 255) ? m_shots + 1 : 255;
                    end else begin
                        m_act = m_deb[0] ? M_LOCK : M_IDLE;
                    end
                end
                if (not_enough) m_abort = 1;
            end
            M_LOCK: if (!m_deb[0]) m_act = M_IDLE;
            M_REF: begin
                m_rem--;
                if (m_rem == 0) m_act = M_IDLE;
            end
            default: m_act = M_IDLE;
        endcase
        for (int i = 0; i < 2; i++) begin
            m_press[i] = 0;
            if (raw[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEBOUNCE) begin
                    m_deb[i] = raw[i]; m_run[i] = 0; m_press[i] = raw[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endfunction

    // Pulse monitors for width, spacing and exclusivity.
    bit prev_t = 0, prev_r = 0, seen_t = 0;
    int hi_t = 0, lo_t = 0, hi_r = 0;
    int t_pulses = 0, r_pulses = 0;

    task automatic compare_cycle();
        check("model_trigger", 32'(trigger), 32'(m_act == M_HIGH));
        check("model_refill", 32'(refill), 32'(m_act == M_REF));
        check("model_burst", 32'(burst_active), 32'((m_act == M_HIGH || m_act == M_GAP) && m_mode == 3'b100));
        check("model_shots", 32'(shots_fired), 32'(m_shots));
        check("exclusive", 32'(trigger & refill), 0);
        if (rst) begin
            prev_t = 0; prev_r = 0; seen_t = 0; hi_t = 0; lo_t = 0; hi_r = 0;
        end else begin
            if (trigger) begin
                if (!prev_t) begin
                    t_pulses++;
                    if (seen_t) check("gap_min", 32'(lo_t >= GAP), 1);
                    seen_t = 1;
                    hi_t = 0;
                end
                hi_t++;
            end else begin
                if (prev_t) begin check("hold_width", hi_t, HOLD); lo_t = 0; end
                lo_t++;
            end
            if (refill) begin
                if (!prev_r) begin r_pulses++; hi_r = 0; end
                hi_r++;
            end else if (prev_r) begin
                check("refill_width", hi_r, REFILL_HOLD);
            end
            prev_t = trigger;
            prev_r = refill;
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_cycle();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; fire_btn = 1'b0; refill_btn = 1'b0; fire_mode = 3'b000; not_enough = 1'b0;
        tick(2);
        rst = 1'b0;
        t_pulses = 0;
        r_pulses = 0;
    endtask

    typedef struct {
        logic       fire;
        logic       refl_btn;
        logic [2:0] mode;
        int         n;
        logic       exp_trig;
        logic       exp_refill;
        logic       exp_burst;
        int         exp_shots;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f_left;
        int r_left;

        // Test 1: clean press in SWING mode; rows advance n edges then check.
        tbl[0] = '{1'b1, 1'b0, 3'b000, 4,  1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 3'b000, 1,  1'b1, 1'b0, 1'b0, 1};
        tbl[2] = '{1'b1, 1'b0, 3'b000, 5,  1'b1, 1'b0, 1'b0, 1};
        tbl[3] = '{1'b1, 1'b0, 3'b000, 1,  1'b0, 1'b0, 1'b0, 1};
        tbl[4] = '{1'b1, 1'b0, 3'b000, 20, 1'b0, 1'b0, 1'b0, 1};
        tbl[5] = '{1'b0, 1'b0, 3'b000, 5,  1'b0, 1'b0, 1'b0, 1};
        tbl[6] = '{1'b1, 1'b0, 3'b000, 5,  1'b1, 1'b0, 1'b0, 2};

        rst = 1'b1; fire_btn = 1'b0; refill_btn = 1'b0; fire_mode = 3'b000; not_enough = 1'b0;
        do_reset();
        check("reset_trigger", 32'(trigger), 0);
        check("reset_refill", 32'(refill), 0);
        check("reset_burst", 32'(burst_active), 0);
        check("reset_shots", 32'(shots_fired), 0);

        for (int i = 0; i < 7; i++) begin
            fire_btn = tbl[i].fire; refill_btn = tbl[i].refl_btn; fire_mode = tbl[i].mode;
            tick(tbl[i].n);
            check($sformatf("t1_row%0d_trigger", i), 32'(trigger), 32'(tbl[i].exp_trig));
            check($sformatf("t1_row%0d_refill", i), 32'(refill), 32'(tbl[i].exp_refill));
            check($sformatf("t1_row%0d_burst", i), 32'(burst_active), 32'(tbl[i].exp_burst));
            check($sformatf("t1_row%0d_shots", i), 32'(shots_fired), tbl[i].exp_shots);
        end
        fire_btn = 1'b0;
        tick(30);

        // Test 2: 1-0-1 bounce then hold.
        do_reset();
        fire_btn = 1'b1; tick(1);
        fire_btn = 1'b0; tick(1);
        fire_btn = 1'b1; tick(4);
        check("t2_no_early_trigger", 32'(trigger), 0);
        tick(1);
        check("t2_trigger_rise", 32'(trigger), 1);
        tick(40);
        check("t2_pulse_count", t_pulses, 1);
        check("t2_shots", 32'(shots_fired), 1);
        fire_btn = 1'b0; tick(10);

        // Test 3: RAPID burst with fire held.
        do_reset();
        fire_mode = 3'b100; fire_btn = 1'b1;
        tick(5);
        check("t3_first_trigger", 32'(trigger), 1);
        check("t3_burst_active", 32'(burst_active), 1);
        tick(48);
        check("t3_mid_burst_active", 32'(burst_active), 1);
        tick(150);
        check("t3_pulse_count", t_pulses, BURST_MAX);
        check("t3_shots", 32'(shots_fired), BURST_MAX);
        check("t3_lockout_burst", 32'(burst_active), 0);
        check("t3_lockout_trigger", 32'(trigger), 0);
        fire_btn = 1'b0; tick(10);

        // Test 4: not_enough during the 3rd RAPID pulse.
        do_reset();
        fire_mode = 3'b100; fire_btn = 1'b1;
        tick(30);
        not_enough = 1'b1; tick(1);
        not_enough = 1'b0; tick(3);
        check("t4_third_pulse_end", 32'(trigger), 1);
        tick(1);
        check("t4_third_pulse_low", 32'(trigger), 0);
        tick(60);
        check("t4_pulse_count", t_pulses, 3);
        check("t4_shots", 32'(shots_fired), 3);
        check("t4_burst_done", 32'(burst_active), 0);
        fire_btn = 1'b0; tick(10);

        // Test 5: simultaneous press, then refill alone.
        do_reset();
        fire_btn = 1'b1; refill_btn = 1'b1;
        tick(5);
        check("t5_fire_wins", 32'(trigger), 1);
        check("t5_no_refill", 32'(refill), 0);
        tick(30);
        check("t5_refill_pulses", r_pulses, 0);
        check("t5_shots", 32'(shots_fired), 1);
        fire_btn = 1'b0; refill_btn = 1'b0;
        tick(10);
        refill_btn = 1'b1;
        tick(5);
        check("t5_refill_high", 32'(refill), 1);
        check("t5_refill_no_trigger", 32'(trigger), 0);

        // Test 6: reset in the 3rd refill cycle.
        tick(1);
        check("t6_refill_second", 32'(refill), 1);
        rst = 1'b1; refill_btn = 1'b0;
        tick(1);
        check("t6_refill_dropped", 32'(refill), 0);
        check("t6_trigger", 32'(trigger), 0);
        check("t6_burst", 32'(burst_active), 0);
        check("t6_shots_cleared", 32'(shots_fired), 0);
        rst = 1'b0;
        tick(10);
        check("t6_idle_refill", 32'(refill), 0);
        check("t6_idle_shots", 32'(shots_fired), 0);

        // Random phase: bouncing buttons, mode changes, aborts, rare resets.
        do_reset();
        f_left = 0;
        r_left = 0;
        for (int c = 0; c < 5000; c++) begin
            if (f_left == 0) begin
                fire_btn  = 1'($urandom_range(0, 1));
                f_left    = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 60);
                fire_mode = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 7));
            end else begin
                f_left--;
            end
            if (r_left == 0) begin
                refill_btn = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
                r_left     = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 40);
            end else begin
                r_left--;
            end
            not_enough = ($urandom_range(0, 30) == 0);
            rst        = ($urandom_range(0, 900) == 0);
            tick(1);
        end
        rst = 1'b0; not_enough = 1'b0; fire_btn = 1'b0; refill_btn = 1'b0;
        tick(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/web_trigger_sequencer.md
Name: web_trigger_sequencer

Overview:
- Upstream stage of the web shooter. Converts raw fire/refill buttons into the clean `trigger` and `refill` level pulses the shooter controller expects.
- Debounces both buttons and guarantees `trigger` and `refill` are never high together.
- Holds each pulse long enough for the controller to traverse WAITING→CHECK→FIRE or WAITING→REFILL, and generates repeated shots in RAPID fire mode (3'b100).

Parameters:
DEBOUNCE, 4, consecutive cycles a raw button must differ from its debounced level before that level flips
HOLD, 6, cycles `trigger` stays high per shot
GAP, 6, cycles `trigger` stays low after each shot
REFILL_HOLD, 6, cycles `refill` stays high per refill request
BURST_MAX, 8, max shots per RAPID burst (1..255)
CNT_W, 8, width of shots_fired

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
fire_btn  in  1  raw fire button, may bounce
refill_btn  in  1  raw refill button, may bounce
fire_mode  in  3  shooter fire mode, sampled at fire press
not_enough  in  1  underflow flag from shooter; aborts burst
trigger  out  1  registered trigger to shooter controller
refill  out  1  registered refill to shooter controller
burst_active  out  1  high while a RAPID burst is in progress
shots_fired  out  CNT_W  saturating count of trigger pulses since reset

Behaviour:
Interface:
- One clock; reset is synchronous and active-high (ports `clk`, `rst`).

Reset:
- On a posedge with rst=1, all state is cleared: trigger=0, refill=0, burst_active=0, shots_fired=0, state=IDLE, debounced levels=0, debounce/phase/burst counters=0, latched mode=0, abort=0.
- Reset mid-pulse drops the output on that same edge.

Debounce (per button):
- The counter increments on each edge where raw != debounced level, and clears on any edge where they are equal.
- When the counter reaches DEBOUNCE, the debounced level flips and the counter clears.
- A press edge is a 0→1 transition of the debounced level; it is a single-cycle internal strobe.

States: IDLE, FIRE_HIGH, FIRE_GAP, LOCKOUT, REFILL_HIGH. All outputs are registered.

IDLE:
- trigger=0, refill=0.
- Fire press → FIRE_HIGH. On entry: latch fire_mode, set burst count=1, clear abort.
- Refill press with no fire press on the same edge → REFILL_HIGH.
- Simultaneous presses: fire wins and the refill press is discarded.

FIRE_HIGH:
- trigger=1 for exactly HOLD cycles, then → FIRE_GAP.
- shots_fired increments once on entry and saturates at all-ones.

FIRE_GAP:
- trigger=0 for exactly GAP cycles. At the end of the gap:
  - → FIRE_HIGH (burst count+1) if latched mode==3'b100, debounced fire=1, burst count<BURST_MAX, and abort=0;
  - else → LOCKOUT if debounced fire=1;
  - else → IDLE.

LOCKOUT:
- Outputs 0. → IDLE once debounced fire=0.
- No new shot until the button is released and pressed again.

REFILL_HIGH:
- refill=1 for exactly REFILL_HOLD cycles, then → IDLE.
- Fire presses during REFILL_HIGH are ignored; re-press is required.
- refill_btn held longer does not extend the pulse or retrigger it; a new press edge is required.

Abort:
- not_enough=1 on any edge in FIRE_HIGH or FIRE_GAP sets abort.
- The current pulse still completes its HOLD/GAP timing; no further burst shots follow.

burst_active:
- 1 in FIRE_HIGH/FIRE_GAP when latched mode==3'b100, otherwise 0.
- Changes to fire_mode after latching have no effect until the next press.

Latency:
- Clean raw rise at edge 0 → debounced level high at edge DEBOUNCE → trigger high at edge DEBOUNCE+1.

Invariants:
- trigger & refill is never 1.
- trigger pulses are exactly HOLD cycles wide, separated by ≥GAP low cycles.

Test Plan:
1. Reset, then fire_btn high and held clean, mode SWING (000) → trigger high for cycles 5..10 after the rise; one pulse only; LOCKOUT until release; shots_fired=1.
2. fire_btn bounces 1-0-1 at 1-cycle intervals, then holds high → no debounced press until 4 stable cycles; exactly one trigger pulse.
3. Mode RAPID (100), fire held indefinitely → exactly 8 pulses of 6 high/6 low; burst_active high throughout; shots_fired=8; then LOCKOUT.
4. RAPID burst with not_enough pulsed high during the 3rd pulse → the 3rd pulse completes its 6 cycles; no 4th pulse; shots_fired=3.
5. fire_btn and refill_btn rise on the same cycle → trigger pulse only, refill stays 0. Release both, then press refill alone → refill high for 6 cycles, trigger 0.
6. Assert rst in the 3rd cycle of a refill pulse → refill=0 on that edge; all outputs 0; shots_fired=0 afterwards.
